alu_arbiter: RTL

Shares a single 32-bit combinational ALU (3-bit ALUop; Result, Overflow, CarryOut, Zero outputs) between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants round-robin, latches the operands, drives the shared ALU for one cycle, registers the result and flags, and holds them until the winning requester accepts them. It sits between the ALU instance and its clients, for example a main pipeline and a multi-cycle helper unit.

---
 rtl/alu_arbiter_if.sv | 77 +++++++
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//
// Bundle of every handshake and bus signal around alu_arbiter:
//   - two request channels   (reqN_valid/ready, reqN_A/B, reqN_op)
//   - two response channels  (rspN_valid/ready) with a shared rsp_result and
//     rsp_flags = {Overflow, CarryOut, Zero}
//   - the shared ALU port    (alu_A/B/ALUop out, alu_Result/flags back in)
//   - dbg_state, the arbiter FSM state (0 = IDLE, 1 = EXEC, 2 = RESP)
//
// Handshake rule for all channels: a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds its payload stable
// while valid is high, and valid never depends on ready.
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters plus the ALU instance)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // Request channel 0
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [DATA_WIDTH-1:0] req0_B;
    logic [2:0]            req0_op;

    // Request channel 1
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [DATA_WIDTH-1:0] req1_B;
    logic [2:0]            req1_op;

    // Response channels; payload is shared, valid selects the owner
    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic [2:0]            rsp_flags;

    // Shared ALU port
    logic [DATA_WIDTH-1:0] alu_A;
    logic [DATA_WIDTH-1:0] alu_B;
    logic [2:0]            alu_ALUop;
    logic [DATA_WIDTH-1:0] alu_Result;
    logic                  alu_Overflow;
    logic                  alu_CarryOut;
    logic                  alu_Zero;

    // FSM state for observation
    logic [1:0]            dbg_state;

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_op,
        input  req1_valid, req1_A, req1_B, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
        input  rsp0_ready, rsp1_ready,
        output alu_A, alu_B, alu_ALUop,
        input  alu_Result, alu_Overflow, alu_CarryOut, alu_Zero,
        output dbg_state
    );

    modport master (
        output req0_valid, req0_A, req0_B, req0_op,
        output req1_valid, req1_A, req1_B, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
        output rsp0_ready, rsp1_ready,
        input  alu_A, alu_B, alu_ALUop,
        output alu_Result, alu_Overflow, alu_CarryOut, alu_Zero,
        input  dbg_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 32-bit ALU between two requesters. One transaction
// is outstanding at a time:
//   IDLE : grant one requester (round robin when both are valid), latch its
//          operands, op code and id.
//   EXEC : the ALU sees the latched operands for exactly one cycle; its
//          Result and {Overflow, CarryOut, Zero} are captured at the end.
//   RESP : the captured result is offered to the owning requester only, and
//          held until that requester accepts it.
// No arithmetic happens here; results and flags are forwarded bit-exact.
//
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous, active-low reset
//   bus    - alu_arbiter_if.slave: request/response channels, ALU port and
//            dbg_state
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic                  prio;        // requester that wins a tie
    logic                  owner;       // requester of the outstanding transaction
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [2:0]            flags_q;
    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;

    // -------------------------------------------------------------------------
    // Grant: combinational, only meaningful in IDLE. Gating with resetn keeps
    // both ready outputs low for the whole time reset is asserted, even though
    // the state register already reads IDLE.
    // -------------------------------------------------------------------------
    logic grant_valid;
    logic grant_id;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (resetn && (state == IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = prio;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Operand mux for the winning requester
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [2:0]            sel_op;

    always_comb begin
        sel_a  = bus.req0_A;
        sel_b  = bus.req0_B;
        sel_op = bus.req0_op;
        if (grant_id) begin
            sel_a  = bus.req1_A;
            sel_b  = bus.req1_B;
            sel_op = bus.req1_op;
        end
    end

    // Only the owner's rsp_ready can release RESP; the other one is ignored.
    logic rsp_accept;

    always_comb begin
        rsp_accept = bus.rsp0_ready;
        if (owner) begin
            rsp_accept = bus.rsp1_ready;
        end
    end

    // -------------------------------------------------------------------------
    // FSM and all registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            prio         <= 1'b0;
            owner        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        op_q  <= sel_op;
                        owner <= grant_id;
                        // The requester that did not win gets the next tie.
                        prio  <= ~grant_id;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    result_q     <= bus.alu_Result;
                    flags_q      <= {bus.alu_Overflow, bus.alu_CarryOut, bus.alu_Zero};
                    rsp0_valid_q <= ~owner;
                    rsp1_valid_q <= owner;
                    state        <= RESP;
                end

                RESP: begin
                    // Operands, result and flags stay untouched while waiting.
                    if (rsp_accept) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid &&  grant_id;

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;

    // The ALU always sees the operand registers, so its inputs are stable
    // across EXEC and RESP.
    assign bus.alu_A      = a_q;
    assign bus.alu_B      = b_q;
    assign bus.alu_ALUop  = op_q;

    assign bus.dbg_state  = state;

endmodule
